// File: rtl/waveform_sample_buffer.sv
// waveform_sample_buffer: decimating circular sample store replayed column-by-column against the VGA scan
module waveform_sample_buffer #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int DECIM     = 4,
  parameter int X_OFFSET  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic signed [8:0]     sample_in,
  input  logic                  freeze,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  output logic signed [8:0]     signal_out,
  output logic                  signal_valid,
  output logic [10:0]           hcount_d,
  output logic [9:0]            vcount_d,
  output logic [ADDR_BITS:0]    fill_count
);
  localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [11:0] XOFF = 12'(X_OFFSET);
  localparam logic [11:0] DEPTH_W = 12'(DEPTH);
  logic signed [8:0] ram [DEPTH];
  logic signed [8:0] rd_data_q, sig_q, sig_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, frame_base_q, frame_base_d, rd_addr;
  logic [ADDR_BITS:0] fill_q, fill_d, frame_fill_q, frame_fill_d;
  logic [CW-1:0] decim_cnt_q, decim_cnt_d;
  logic [11:0] col;
  logic [10:0] h1_q, hd_q;
  logic [9:0] v1_q, vd_q;
  logic ok1_q, ok1_d, val_q, accept, we, latch;
  always_comb begin
    accept = sample_valid && !freeze;
    we = accept && decim_cnt_q == '0;
    wr_ptr_d = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_d = (we && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    decim_cnt_d = !accept ? decim_cnt_q : (decim_cnt_q == CW'(DECIM-1)) ? '0 : decim_cnt_q + 1'b1;
    latch = hcount == '0 && vcount == '0;
    frame_base_d = latch ? ((fill_q == FULL) ? wr_ptr_q : '0) : frame_base_q;
    frame_fill_d = latch ? fill_q : frame_fill_q;
    // a column left of X_OFFSET underflows to >= 2048 and so fails both bounds
    col = {1'b0, hcount} - XOFF;
    ok1_d = col < DEPTH_W && col < 12'(frame_fill_d);
    rd_addr = frame_base_d + col[ADDR_BITS-1:0];
    sig_d = ok1_q ? rd_data_q : '0;
  end
  always_ff @(posedge clock) begin
    if (we && !reset) ram[wr_ptr_q] <= sample_in;
    rd_data_q <= ram[rd_addr];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      decim_cnt_q <= '0;
      fill_q <= '0;
      frame_base_q <= '0;
      frame_fill_q <= '0;
      ok1_q <= 1'b0;
      h1_q <= '0;
      v1_q <= '0;
      sig_q <= '0;
      val_q <= 1'b0;
      hd_q <= '0;
      vd_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      decim_cnt_q <= decim_cnt_d;
      fill_q <= fill_d;
      frame_base_q <= frame_base_d;
      frame_fill_q <= frame_fill_d;
      ok1_q <= ok1_d;
      h1_q <= hcount;
      v1_q <= vcount;
      sig_q <= sig_d;
      val_q <= ok1_q;
      hd_q <= h1_q;
      vd_q <= v1_q;
    end
  end
  assign signal_out = sig_q;
  assign signal_valid = val_q;
  assign hcount_d = hd_q;
  assign vcount_d = vd_q;
  assign fill_count = fill_q;
endmodule

// File: tb/tb_waveform_sample_buffer.sv
// tb_waveform_sample_buffer: directed vectors against a DECIM=1 and a DECIM=4 instance sharing stimulus
module tb_waveform_sample_buffer;
  logic clock = 1'b0;
  logic reset, sample_valid, freeze;
  logic signed [8:0] sample_in;
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic signed [8:0] s1, s4;
  logic v1, v4;
  logic [10:0] hd1, hd4, f1, f4;
  logic [9:0] vd1, vd4;
  int errors = 0;
  int checks = 0;
  logic signed [8:0] o1_sig [0:1099];
  logic signed [8:0] o4_sig [0:1099];
  logic o1_val [0:1099];
  logic o4_val [0:1099];
  int o1_hd [0:1099];
  typedef struct {int col; int sig; bit val;} vec_t;
  vec_t t2 [8];
  waveform_sample_buffer #(.DECIM(1)) dut1 (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .freeze(freeze), .hcount(hcount), .vcount(vcount), .signal_out(s1), .signal_valid(v1),
    .hcount_d(hd1), .vcount_d(vd1), .fill_count(f1));
  waveform_sample_buffer #(.DECIM(4)) dut4 (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .freeze(freeze), .hcount(hcount), .vcount(vcount), .signal_out(s4), .signal_valid(v4),
    .hcount_d(hd4), .vcount_d(vd4), .fill_count(f4));
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic write(input int v);
    sample_in = 9'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask
  task automatic scan(input int n, input int v);
    vcount = 10'(v);
    for (int h = 0; h <= n; h++) begin
      hcount = 11'(h);
      tick();
      if (h >= 1) begin
        o1_sig[h-1] = s1;
        o1_val[h-1] = v1;
        o1_hd[h-1] = int'(hd1);
        o4_sig[h-1] = s4;
        o4_val[h-1] = v4;
      end
    end
    hcount = 11'd1100;
    vcount = 10'd5;
  endtask
  initial begin
    t2[0] = '{0, 1, 1'b1};
    t2[1] = '{1, 2, 1'b1};
    t2[2] = '{2, 3, 1'b1};
    t2[3] = '{3, 4, 1'b1};
    t2[4] = '{4, 5, 1'b1};
    t2[5] = '{5, 0, 1'b0};
    t2[6] = '{6, 0, 1'b0};
    t2[7] = '{7, 0, 1'b0};
    sample_valid = 1'b0;
    sample_in = '0;
    freeze = 1'b0;
    hcount = 11'd1100;
    vcount = 10'd5;
    do_reset();
    chk("rst_sig", int'(s1), 0);
    chk("rst_val", int'(v1), 0);
    chk("rst_fill", int'(f1), 0);
    chk("rst_hd", int'(hd1), 0);
    for (int h = 0; h < 10; h++) begin
      hcount = 11'(h);
      vcount = 10'd0;
      tick();
      chk($sformatf("idle_sig%0d", h), int'(s1), 0);
      chk($sformatf("idle_val%0d", h), int'(v1), 0);
      chk($sformatf("idle_fill%0d", h), int'(f1), 0);
      chk($sformatf("idle_hd%0d", h), int'(hd1), h > 0 ? h - 1 : 0);
    end
    hcount = 11'd1100;
    vcount = 10'd5;
    do_reset();
    for (int i = 1; i <= 5; i++) write(i);
    chk("d1_fill5", int'(f1), 5);
    chk("d4_fill5", int'(f4), 2);
    scan(8, 0);
    foreach (t2[i]) begin
      chk($sformatf("t2_sig%0d", t2[i].col), int'(o1_sig[t2[i].col]), t2[i].sig);
      chk($sformatf("t2_val%0d", t2[i].col), int'(o1_val[t2[i].col]), int'(t2[i].val));
      chk($sformatf("t2_lat%0d", t2[i].col), o1_hd[t2[i].col], t2[i].col);
    end
    do_reset();
    for (int i = 0; i < 16; i++) write(i);
    chk("d4_fill16", int'(f4), 4);
    chk("d1_fill16", int'(f1), 16);
    scan(5, 0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("d4_sig%0d", c), int'(o4_sig[c]), 4 * c);
      chk($sformatf("d4_val%0d", c), int'(o4_val[c]), 1);
    end
    chk("d4_val4", int'(o4_val[4]), 0);
    do_reset();
    for (int i = 0; i < 1030; i++) write(i % 256);
    chk("wrap_fill", int'(f1), 1024);
    chk("wrap_d4_fill", int'(f4), 258);
    scan(1025, 0);
    chk("wrap_c0", int'(o1_sig[0]), 6);
    chk("wrap_c1", int'(o1_sig[1]), 7);
    chk("wrap_c1017", int'(o1_sig[1017]), 255);
    chk("wrap_c1018", int'(o1_sig[1018]), 0);
    chk("wrap_c1023", int'(o1_sig[1023]), 5);
    chk("wrap_v0", int'(o1_val[0]), 1);
    chk("wrap_v1023", int'(o1_val[1023]), 1);
    chk("wrap_v1024", int'(o1_val[1024]), 0);
    chk("wrap_d4_c257", int'(o4_sig[257]), 4);
    chk("wrap_d4_v257", int'(o4_val[257]), 1);
    chk("wrap_d4_v258", int'(o4_val[258]), 0);
    do_reset();
    write(10);
    write(20);
    write(30);
    freeze = 1'b1;
    for (int i = 0; i < 50; i++) write(99);
    chk("frz_fill", int'(f1), 3);
    chk("frz_d4_fill", int'(f4), 1);
    freeze = 1'b0;
    write(40);
    chk("unfrz_fill", int'(f1), 4);
    chk("unfrz_d4_fill", int'(f4), 1);
    scan(5, 0);
    chk("unfrz_c2", int'(o1_sig[2]), 30);
    chk("unfrz_c3", int'(o1_sig[3]), 40);
    chk("unfrz_v3", int'(o1_val[3]), 1);
    chk("unfrz_v4", int'(o1_val[4]), 0);
    hcount = 11'd300;
    vcount = 10'd200;
    write(50);
    write(60);
    write(-70);
    chk("mid_fill", int'(f1), 7);
    scan(8, 200);
    chk("mid_v3", int'(o1_val[3]), 1);
    chk("mid_c3", int'(o1_sig[3]), 40);
    chk("mid_v4", int'(o1_val[4]), 0);
    chk("mid_c4", int'(o1_sig[4]), 0);
    scan(8, 0);
    chk("new_c4", int'(o1_sig[4]), 50);
    chk("new_c6", int'(o1_sig[6]), -70);
    chk("new_v6", int'(o1_val[6]), 1);
    chk("new_v7", int'(o1_val[7]), 0);
    hcount = 11'd2;
    vcount = 10'd200;
    tick();
    tick();
    chk("pre_rst_val", int'(v1), 1);
    chk("pre_rst_sig", int'(s1), 30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_sig", int'(s1), 0);
    chk("mrst_val", int'(v1), 0);
    chk("mrst_hd", int'(hd1), 0);
    chk("mrst_vd", int'(vd1), 0);
    chk("mrst_fill", int'(f1), 0);
    scan(4, 0);
    for (int c = 0; c < 4; c++) chk($sformatf("mrst_v%0d", c), int'(o1_val[c]), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
